// File: rtl/change_dispenser.sv
// change_dispenser
//   Returns change through the physical coin hoppers. A requested amount is
//   paid out greedily (largest coin first), each eject is handshaked with the
//   chute sensor, and per-hopper inventory is tracked. A hopper that never
//   reports a coin is flagged as jammed, treated as empty, and the greedy
//   selection falls through to the next smaller coin.
//
// Optional feature: define DOLLAR_COIN_EN to add a 100-cent dollar-coin
//   hopper (ports load_o, eject_o, cnt_o), tried before the quarter.
//
// Ports:
//   clk, reset                 system clock, synchronous active-high reset
//   req_valid, req_amount      change request and amount in cents
//   req_ready                  request can be accepted this cycle
//   load_en, load_q/d/n        load hopper inventories (IDLE only)
//   eject_q/d/n                eject command per hopper (one-hot or idle)
//   coin_sense                 one-cycle pulse, coin has left the chute
//   busy, done                 not-idle flag, completion pulse
//   short_amount               cents not returned for the last request
//   fault                      sticky hopper-timeout flag
//   cnt_q/d/n                  current hopper inventories
//
// state  | meaning
// IDLE   | waiting for a request or an inventory load
// SELECT | pick the largest coin that fits and is in stock
// EJECT  | eject line high, waiting for coin_sense or timeout
// GAP    | hopper recovery time between ejects
// FINISH | one-cycle done pulse

module change_dispenser #(
  parameter int AMT_W   = 9,
  parameter int CNT_W   = 6,
  parameter int TIMEOUT = 16,
  parameter int GAP_CYC = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  input  logic             load_en,
  input  logic [CNT_W-1:0] load_q,
  input  logic [CNT_W-1:0] load_d,
  input  logic [CNT_W-1:0] load_n,
`ifdef DOLLAR_COIN_EN
  input  logic [CNT_W-1:0] load_o,
  output logic             eject_o,
  output logic [CNT_W-1:0] cnt_o,
`endif
  output logic             eject_q,
  output logic             eject_d,
  output logic             eject_n,
  input  logic             coin_sense,
  output logic             busy,
  output logic             done,
  output logic [AMT_W-1:0] short_amount,
  output logic             fault,
  output logic [CNT_W-1:0] cnt_q,
  output logic [CNT_W-1:0] cnt_d,
  output logic [CNT_W-1:0] cnt_n
);

  localparam int TMR_MAX = (TIMEOUT > GAP_CYC) ? TIMEOUT : GAP_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_EJECT,
    S_GAP,
    S_FINISH
  } state_t;

  typedef enum logic [1:0] {
    COIN_O,
    COIN_Q,
    COIN_D,
    COIN_N
  } coin_t;

  state_t           state_q, state_d;
  coin_t            sel_q, sel_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [AMT_W-1:0] short_q, short_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] qtr_cnt_q, qtr_cnt_d;
  logic [CNT_W-1:0] dim_cnt_q, dim_cnt_d;
  logic [CNT_W-1:0] nkl_cnt_q, nkl_cnt_d;
`ifdef DOLLAR_COIN_EN
  logic [CNT_W-1:0] dol_cnt_q, dol_cnt_d;
`endif
  logic [AMT_W-1:0] coin_val;

  always_comb begin
    coin_val = '0;
    unique case (sel_q)
      COIN_O:  coin_val = AMT_W'(100);
      COIN_Q:  coin_val = AMT_W'(25);
      COIN_D:  coin_val = AMT_W'(10);
      COIN_N:  coin_val = AMT_W'(5);
      default: coin_val = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    tmr_d     = tmr_q;
    rem_d     = rem_q;
    short_d   = short_q;
    fault_d   = fault_q;
    qtr_cnt_d = qtr_cnt_q;
    dim_cnt_d = dim_cnt_q;
    nkl_cnt_d = nkl_cnt_q;
`ifdef DOLLAR_COIN_EN
    dol_cnt_d = dol_cnt_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        // A load takes the whole cycle; req_ready is low so no request is taken.
        if (load_en) begin
          qtr_cnt_d = load_q;
          dim_cnt_d = load_d;
          nkl_cnt_d = load_n;
`ifdef DOLLAR_COIN_EN
          dol_cnt_d = load_o;
`endif
        end else if (req_valid) begin
          rem_d   = req_amount;
          short_d = '0;
          state_d = S_SELECT;
        end
      end

      S_SELECT: begin
        state_d = S_EJECT;
        tmr_d   = TMR_W'(TIMEOUT - 1);
`ifdef DOLLAR_COIN_EN
        if (rem_q >= AMT_W'(100) && dol_cnt_q != '0) sel_d = COIN_O;
        else
`endif
        if (rem_q >= AMT_W'(25) && qtr_cnt_q != '0) sel_d = COIN_Q;
        else if (rem_q >= AMT_W'(10) && dim_cnt_q != '0) sel_d = COIN_D;
        else if (rem_q >= AMT_W'(5) && nkl_cnt_q != '0) sel_d = COIN_N;
        else begin
          short_d = rem_q;
          state_d = S_FINISH;
        end
      end

      S_EJECT: begin
        if (coin_sense || tmr_q == '0) begin
          if (coin_sense) begin
            rem_d   = rem_q - coin_val;
            tmr_d   = TMR_W'(GAP_CYC - 1);
            state_d = S_GAP;
          end else begin
            // Jammed hopper: mark it empty so selection falls through.
            fault_d = 1'b1;
            state_d = S_SELECT;
          end
          unique case (sel_q)
            COIN_Q:  qtr_cnt_d = coin_sense ? qtr_cnt_q - 1'b1 : '0;
            COIN_D:  dim_cnt_d = coin_sense ? dim_cnt_q - 1'b1 : '0;
            COIN_N:  nkl_cnt_d = coin_sense ? nkl_cnt_q - 1'b1 : '0;
`ifdef DOLLAR_COIN_EN
            COIN_O:  dol_cnt_d = coin_sense ? dol_cnt_q - 1'b1 : '0;
`endif
            default: ;
          endcase
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end

      S_GAP: begin
        if (tmr_q == '0) state_d = S_SELECT;
        else             tmr_d   = tmr_q - 1'b1;
      end

      S_FINISH: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      sel_q     <= COIN_Q;
      tmr_q     <= '0;
      rem_q     <= '0;
      short_q   <= '0;
      fault_q   <= 1'b0;
      qtr_cnt_q <= '0;
      dim_cnt_q <= '0;
      nkl_cnt_q <= '0;
`ifdef DOLLAR_COIN_EN
      dol_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      tmr_q     <= tmr_d;
      rem_q     <= rem_d;
      short_q   <= short_d;
      fault_q   <= fault_d;
      qtr_cnt_q <= qtr_cnt_d;
      dim_cnt_q <= dim_cnt_d;
      nkl_cnt_q <= nkl_cnt_d;
`ifdef DOLLAR_COIN_EN
      dol_cnt_q <= dol_cnt_d;
`endif
    end
  end

  // Eject lines decode straight from state, so they drop the cycle after
  // the coin is sensed, on timeout, or on reset.
  assign eject_q      = (state_q == S_EJECT) && (sel_q == COIN_Q);
  assign eject_d      = (state_q == S_EJECT) && (sel_q == COIN_D);
  assign eject_n      = (state_q == S_EJECT) && (sel_q == COIN_N);
`ifdef DOLLAR_COIN_EN
  assign eject_o      = (state_q == S_EJECT) && (sel_q == COIN_O);
  assign cnt_o        = dol_cnt_q;
`endif
  assign req_ready    = (state_q == S_IDLE) && !load_en;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_FINISH);
  assign short_amount = short_q;
  assign fault        = fault_q;
  assign cnt_q        = qtr_cnt_q;
  assign cnt_d        = dim_cnt_q;
  assign cnt_n        = nkl_cnt_q;

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;
  localparam int AMT_W   = 9;
  localparam int CNT_W   = 6;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             reset, req_valid, load_en, coin_sense;
  logic [AMT_W-1:0] req_amount;
  logic [CNT_W-1:0] load_q, load_d, load_n;
  logic             req_ready, eject_q, eject_d, eject_n, busy, done, fault;
  logic [AMT_W-1:0] short_amount;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_n;
`ifdef DOLLAR_COIN_EN
  logic [CNT_W-1:0] load_o, cnt_o;
  logic             eject_o;
`endif

  change_dispenser #(.AMT_W(AMT_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .GAP_CYC(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_amount(req_amount),
    .req_ready(req_ready), .load_en(load_en), .load_q(load_q), .load_d(load_d),
    .load_n(load_n),
`ifdef DOLLAR_COIN_EN
    .load_o(load_o), .eject_o(eject_o), .cnt_o(cnt_o),
`endif
    .eject_q(eject_q), .eject_d(eject_d), .eject_n(eject_n),
    .coin_sense(coin_sense), .busy(busy), .done(done), .short_amount(short_amount),
    .fault(fault), .cnt_q(cnt_q), .cnt_d(cnt_d), .cnt_n(cnt_n)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: index 0 dollar, 1 quarter, 2 dime, 3 nickel.
  int mcnt[4];
  int coin_v[4] = '{100, 25, 10, 5};
  bit mfault;
  int exp_q[$];
  int exp_short;

  function automatic int eject_val();
    int v = 0;
    if (eject_q) v = 25;
    if (eject_d) v = 10;
    if (eject_n) v = 5;
`ifdef DOLLAR_COIN_EN
    if (eject_o) v = 100;
`endif
    return v;
  endfunction

  function automatic int eject_cnt();
    int c = int'(eject_q) + int'(eject_d) + int'(eject_n);
`ifdef DOLLAR_COIN_EN
    c += int'(eject_o);
`endif
    return c;
  endfunction

  // Greedy payout from plain arithmetic; the eject with ordinal 'jam' never
  // gets a sensor reply, so that hopper is emptied and flagged.
  task automatic model(input int amt, input int jam);
    int rem = amt;
    int n = 0;
    exp_q.delete();
    forever begin
      int pick = -1;
      for (int i = 0; i < 4; i++)
        if (pick < 0 && rem >= coin_v[i] && mcnt[i] > 0) pick = i;
      if (pick < 0) break;
      exp_q.push_back(coin_v[pick]);
      if (n == jam) begin
        mcnt[pick] = 0;
        mfault = 1'b1;
      end else begin
        rem -= coin_v[pick];
        mcnt[pick]--;
      end
      n++;
    end
    exp_short = rem;
  endtask

  task automatic load_counts(input int o, input int q, input int d, input int n);
    @(negedge clk);
    load_en = 1'b1;
    load_q = CNT_W'(q); load_d = CNT_W'(d); load_n = CNT_W'(n);
`ifdef DOLLAR_COIN_EN
    load_o = CNT_W'(o);
    mcnt[0] = o;
`else
    mcnt[0] = 0;
`endif
    mcnt[1] = q; mcnt[2] = d; mcnt[3] = n;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Watches one request from the cycle after acceptance to its done pulse,
  // playing the coin sensor. fast=1 answers in the first EJECT cycle.
  task automatic run_to_done(input string name, input int jam, input bit fast, input bit chk_lat);
    int k = 0, cur = -1, hold = 0, delay = -1, cyc = 0, multi = 0;
    bit prev = 1'b0, seen_done = 1'b0;
    while (cyc < 800 && !seen_done) begin
      @(negedge clk);
      cyc++;
      req_valid  = 1'b0;
      coin_sense = 1'b0;
      if (eject_cnt() > 1) multi++;
      if (done) begin
        seen_done = 1'b1;
      end else if (eject_val() != 0) begin
        if (!prev) begin
          n_checks++;
          if (k >= exp_q.size() || eject_val() != exp_q[k]) begin
            n_fail++;
            $display("FAIL %s coin#%0d: got %0d cents, expected %0d", name, k, eject_val(),
                     (k < exp_q.size()) ? exp_q[k] : -1);
          end
          delay = (k == jam) ? -1 : (fast ? 0 : int'($urandom_range(0, 3)));
          hold = 0;
          cur = k;
          k++;
        end
        hold++;
        if (delay == 0) coin_sense = 1'b1;
        if (delay >= 0) delay--;
        prev = 1'b1;
      end else begin
        if (prev && cur == jam) begin
          n_checks++;
          if (hold != TIMEOUT) begin
            n_fail++;
            $display("FAIL %s jam_hold: got %0d cycles, expected %0d", name, hold, TIMEOUT);
          end
        end
        prev = 1'b0;
        if (!fast && $urandom_range(0, 3) == 0) coin_sense = 1'b1;
      end
    end
    coin_sense = 1'b0;
    n_checks++;
    if (!seen_done) begin
      n_fail++;
      $display("FAIL %s done_timeout: no done within %0d cycles", name, cyc);
    end
    if (chk_lat) begin
      n_checks++;
      if (cyc != 4 * exp_q.size() + 2) begin
        n_fail++;
        $display("FAIL %s latency: got %0d, expected %0d", name, cyc, 4 * exp_q.size() + 2);
      end
    end
    n_checks++;
    if (k != exp_q.size() || multi != 0) begin
      n_fail++;
      $display("FAIL %s eject_count: got %0d (overlap %0d), expected %0d", name, k, multi, exp_q.size());
    end
    n_checks++;
    if (short_amount !== AMT_W'(exp_short)) begin
      n_fail++;
      $display("FAIL %s short: got %0d, expected %0d", name, short_amount, exp_short);
    end
    n_checks++;
    if (cnt_q !== CNT_W'(mcnt[1]) || cnt_d !== CNT_W'(mcnt[2]) || cnt_n !== CNT_W'(mcnt[3])) begin
      n_fail++;
      $display("FAIL %s counts: got q%0d d%0d n%0d, expected q%0d d%0d n%0d", name,
               cnt_q, cnt_d, cnt_n, mcnt[1], mcnt[2], mcnt[3]);
    end
`ifdef DOLLAR_COIN_EN
    n_checks++;
    if (cnt_o !== CNT_W'(mcnt[0])) begin
      n_fail++;
      $display("FAIL %s cnt_o: got %0d, expected %0d", name, cnt_o, mcnt[0]);
    end
`endif
    n_checks++;
    if (fault !== mfault || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s fault/busy: got %b/%b, expected %b/1", name, fault, busy, mfault);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s after_done: got done=%b busy=%b ready=%b, expected 0 0 1", name, done, busy, req_ready);
    end
  endtask

  task automatic do_request(input string name, input int amt, input int jam, input bit fast, input bit chk_lat);
    model(amt, jam);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s ready_before: got %b, expected 1", name, req_ready);
    end
    req_valid  = 1'b1;
    req_amount = AMT_W'(amt);
    run_to_done(name, jam, fast, chk_lat);
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; load_en = 1'b0; coin_sense = 1'b0;
    req_amount = '0; load_q = '0; load_d = '0; load_n = '0;
`ifdef DOLLAR_COIN_EN
    load_o = '0;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;
    mcnt = '{0, 0, 0, 0};
    mfault = 1'b0;
    @(negedge clk);
    n_checks++;
    if (eject_cnt() != 0 || done !== 1'b0 || fault !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ctrl: got ej=%0d done=%b fault=%b busy=%b ready=%b, expected 0 0 0 0 1",
               eject_cnt(), done, fault, busy, req_ready);
    end
    n_checks++;
    if (short_amount !== '0 || cnt_q !== '0 || cnt_d !== '0 || cnt_n !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got short=%0d q%0d d%0d n%0d, expected all 0", short_amount, cnt_q, cnt_d, cnt_n);
    end
  endtask

  task automatic test_directed();
    load_counts(0, 4, 4, 4);
    do_request("q2d1n1_65", 65, -1, 1'b1, 1'b1);
    load_counts(0, 1, 0, 1);
    do_request("no_dime_40", 40, -1, 1'b0, 1'b0);
    load_counts(0, 9, 9, 9);
    do_request("odd_37", 37, -1, 1'b0, 1'b0);
    load_counts(0, 2, 5, 0);
    do_request("jam_q_30", 30, 0, 1'b0, 1'b0);
    load_counts(0, 2, 2, 2);
    do_request("below_nickel_4", 4, -1, 1'b1, 1'b1);
    do_request("zero", 0, -1, 1'b1, 1'b1);
    do_request("exact_25", 25, -1, 1'b1, 1'b1);
    do_request("jam_last_n", 5, 0, 1'b1, 1'b0);
  endtask

  task automatic test_load_and_request();
    load_counts(0, 1, 1, 1);
    @(negedge clk);
    load_en = 1'b1; req_valid = 1'b1; req_amount = AMT_W'(45);
    load_q = CNT_W'(3); load_d = CNT_W'(3); load_n = CNT_W'(3);
`ifdef DOLLAR_COIN_EN
    load_o = '0;
`endif
    #1;
    n_checks++;
    if (req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL load_req_ready: got %b, expected 0", req_ready);
    end
    mcnt = '{0, 3, 3, 3};
    @(negedge clk);
    n_checks++;
    if (cnt_q !== CNT_W'(3) || cnt_d !== CNT_W'(3) || cnt_n !== CNT_W'(3) || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL load_req_counts: got q%0d d%0d n%0d busy=%b, expected 3 3 3 0", cnt_q, cnt_d, cnt_n, busy);
    end
    load_en = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL load_req_ready_next: got %b, expected 1", req_ready);
    end
    model(45, -1);
    run_to_done("load_then_req_45", -1, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_eject();
    int wait_cyc = 0;
    int dones = 0;
    load_counts(0, 4, 4, 4);
    @(negedge clk);
    req_valid = 1'b1; req_amount = AMT_W'(50);
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      wait_cyc++;
    end while (!eject_q && wait_cyc < 20);
    n_checks++;
    if (!eject_q) begin
      n_fail++;
      $display("FAIL rst_mid_eject_start: got eject_q=%b, expected 1", eject_q);
    end
    reset = 1'b1;
    mcnt = '{0, 0, 0, 0};
    mfault = 1'b0;
    @(negedge clk);
    n_checks++;
    if (eject_q !== 1'b0 || busy !== 1'b0 || cnt_q !== '0 || cnt_d !== '0 || cnt_n !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_eject: got ej=%b busy=%b q%0d d%0d n%0d, expected 0 0 0 0 0",
               eject_q, busy, cnt_q, cnt_d, cnt_n);
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_ready_after: got %b, expected 1", req_ready);
    end
    repeat (10) begin
      @(negedge clk);
      if (done) dones++;
    end
    n_checks++;
    if (dones != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_no_done: got %0d done pulses busy=%b, expected 0 0", dones, busy);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      int jam;
      bit fast;
      if (it == 0 || $urandom_range(0, 2) == 0)
        load_counts($urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6));
      jam  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
      fast = 1'($urandom_range(0, 1));
      do_request("random", $urandom_range(0, 260), jam, fast, fast && jam < 0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_load_and_request();
    test_reset_mid_eject();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
